// File: rtl/acc_spi_seq.sv
// rtl/acc_spi_seq.sv - SPI master and init/read sequencer for a LIS3DH-class accelerometer
//
// Ports:
//   clk12m, rst              12 MHz clock, synchronous active-high reset
//   enable                   run request (level), sampled at frame boundaries and in WAIT
//   use_int                  1: acc_int1 rising edge triggers reads, 0: poll timer does
//   acc_int1                 asynchronous interrupt from the accelerometer
//   acc_sclk, acc_mosi       SPI mode 3 clock (idles high) and data out
//   acc_miso, acc_cs         SPI data in, active-low chip select
//   acc_x, acc_y, acc_z      signed axis samples, updated together
//   sample_valid             one-cycle strobe when the axis registers update
//   id_ok                    last WHO_AM_I read returned 0x33
//   busy                     sequencer is in any state other than IDLE or WAIT
module acc_spi_seq #(
    parameter int         CLK_DIV     = 3,
    parameter logic [7:0] CFG_CTRL1   = 8'h77,
    parameter logic [7:0] CFG_CTRL4   = 8'h88,
    parameter int         POLL_PERIOD = 120000
) (
    input  logic               clk12m,
    input  logic               rst,
    input  logic               enable,
    input  logic               use_int,
    input  logic               acc_int1,
    output logic               acc_sclk,
    output logic               acc_mosi,
    input  logic               acc_miso,
    output logic               acc_cs,
    output logic signed [15:0] acc_x,
    output logic signed [15:0] acc_y,
    output logic signed [15:0] acc_z,
    output logic               sample_valid,
    output logic               id_ok,
    output logic               busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ID, ST_CFG1, ST_CFG4, ST_WAIT, ST_READ, ST_PUBLISH
    } state_t;

    // Every frame starts with a CS-high gap, so back-to-back frames are always separated.
    typedef enum logic [2:0] {
        PH_GAP, PH_SETUP, PH_LOW, PH_HIGH, PH_HOLD
    } phase_t;

    localparam int            PW        = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
    localparam logic [8:0]    HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0]    GAP_LAST  = 9'(2 * CLK_DIV - 1);

    state_t        state;
    phase_t        phase;
    logic [8:0]    div_cnt;
    logic [5:0]    bit_cnt;
    logic [15:0]   tx_shift;
    logic [47:0]   rx_shift;
    logic          int_meta;
    logic          int_sync;
    logic          int_prev;
    logic [PW-1:0] poll_cnt;
    logic          pending;

    logic          half_done;
    logic [5:0]    frame_bits;
    logic          poll_wrap;
    logic          int_rise;

    assign half_done  = (div_cnt == HALF_LAST);
    assign frame_bits = (state == ST_READ) ? 6'd56 : 6'd16;
    assign poll_wrap  = !use_int && (state != ST_IDLE) && (poll_cnt == POLL_LAST);
    assign int_rise   = use_int && int_sync && !int_prev;

    always_ff @(posedge clk12m) begin
        if (rst) begin
            state        <= ST_IDLE;
            phase        <= PH_GAP;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            acc_cs       <= 1'b1;
            acc_sclk     <= 1'b1;
            acc_mosi     <= 1'b0;
            acc_x        <= '0;
            acc_y        <= '0;
            acc_z        <= '0;
            sample_valid <= 1'b0;
            id_ok        <= 1'b0;
            busy         <= 1'b0;
            int_meta     <= 1'b0;
            int_sync     <= 1'b0;
            int_prev     <= 1'b0;
            poll_cnt     <= '0;
            pending      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            int_meta     <= acc_int1;
            int_sync     <= int_meta;
            int_prev     <= int_sync;

            if (!use_int && state != ST_IDLE) begin
                poll_cnt <= poll_wrap ? '0 : poll_cnt + PW'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state    <= ST_ID;
                        busy     <= 1'b1;
                        tx_shift <= {8'h8F, 8'h00};
                    end
                end

                ST_WAIT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (pending) begin
                        state    <= ST_READ;
                        busy     <= 1'b1;
                        pending  <= 1'b0;
                        tx_shift <= {8'hE8, 8'h00};
                    end
                end

                ST_PUBLISH: begin
                    // rx_shift holds XL XH YL YH ZL ZH from MSB down; the command byte fell off the top.
                    acc_x        <= {rx_shift[39:32], rx_shift[47:40]};
                    acc_y        <= {rx_shift[23:16], rx_shift[31:24]};
                    acc_z        <= {rx_shift[7:0],   rx_shift[15:8]};
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= enable ? ST_WAIT : ST_IDLE;
                end

                ST_ID, ST_CFG1, ST_CFG4, ST_READ: begin
                    case (phase)
                        PH_GAP: begin
                            if (div_cnt == GAP_LAST) begin
                                div_cnt <= '0;
                                phase   <= PH_SETUP;
                                acc_cs  <= 1'b0;
                            end else begin
                                div_cnt <= div_cnt + 9'd1;
                            end
                        end
                        PH_SETUP: begin
                            if (half_done) begin
                                div_cnt  <= '0;
                                phase    <= PH_LOW;
                                acc_sclk <= 1'b0;
                                acc_mosi <= tx_shift[15];
                                tx_shift <= {tx_shift[14:0], 1'b0};
                            end else begin
                                div_cnt <= div_cnt + 9'd1;
                            end
                        end
                        PH_LOW: begin
                            if (half_done) begin
                                div_cnt  <= '0;
                                phase    <= PH_HIGH;
                                acc_sclk <= 1'b1;
                                rx_shift <= {rx_shift[46:0], acc_miso};
                                bit_cnt  <= bit_cnt + 6'd1;
                            end else begin
                                div_cnt <= div_cnt + 9'd1;
                            end
                        end
                        PH_HIGH: begin
                            if (half_done) begin
                                div_cnt <= '0;
                                if (bit_cnt == frame_bits) begin
                                    phase <= PH_HOLD;
                                end else begin
                                    phase    <= PH_LOW;
                                    acc_sclk <= 1'b0;
                                    acc_mosi <= tx_shift[15];
                                    tx_shift <= {tx_shift[14:0], 1'b0};
                                end
                            end else begin
                                div_cnt <= div_cnt + 9'd1;
                            end
                        end
                        PH_HOLD: begin
                            if (half_done) begin
                                div_cnt  <= '0;
                                bit_cnt  <= '0;
                                phase    <= PH_GAP;
                                acc_cs   <= 1'b1;
                                acc_mosi <= 1'b0;
                                case (state)
                                    ST_ID: begin
                                        id_ok <= (rx_shift[7:0] == 8'h33);
                                        if (enable) begin
                                            state    <= ST_CFG1;
                                            tx_shift <= {8'h20, CFG_CTRL1};
                                        end else begin
                                            state <= ST_IDLE;
                                            busy  <= 1'b0;
                                        end
                                    end
                                    ST_CFG1: begin
                                        if (enable) begin
                                            state    <= ST_CFG4;
                                            tx_shift <= {8'h23, CFG_CTRL4};
                                        end else begin
                                            state <= ST_IDLE;
                                            busy  <= 1'b0;
                                        end
                                    end
                                    ST_CFG4: begin
                                        state <= enable ? ST_WAIT : ST_IDLE;
                                        busy  <= 1'b0;
                                    end
                                    default: begin
                                        // A started READ always publishes, even if enable dropped.
                                        state <= ST_PUBLISH;
                                    end
                                endcase
                            end else begin
                                div_cnt <= div_cnt + 9'd1;
                            end
                        end
                        default: begin
                            phase <= PH_GAP;
                        end
                    endcase
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A trigger arriving on the cycle pending is consumed must not be lost.
            if (poll_wrap || int_rise) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_acc_spi_seq.sv
// tb/tb_acc_spi_seq.sv - randomized self-checking bench for acc_spi_seq with a register-level slave model
module tb_acc_spi_seq;

    localparam int CLK_DIV = 3;
    localparam int POLL    = 1000;
    localparam int LEN_2B  = 2 * CLK_DIV + 16 * CLK_DIV * 2;
    localparam int LEN_7B  = 2 * CLK_DIV + 16 * CLK_DIV * 7;

    logic               clk12m = 1'b0;
    logic               rst;
    logic               enable;
    logic               use_int;
    logic               acc_int1;
    logic               acc_miso = 1'b0;
    logic               acc_sclk;
    logic               acc_mosi;
    logic               acc_cs;
    logic signed [15:0] acc_x;
    logic signed [15:0] acc_y;
    logic signed [15:0] acc_z;
    logic               sample_valid;
    logic               id_ok;
    logic               busy;

    acc_spi_seq #(
        .CLK_DIV    (CLK_DIV),
        .CFG_CTRL1  (8'h77),
        .CFG_CTRL4  (8'h88),
        .POLL_PERIOD(POLL)
    ) dut (
        .clk12m      (clk12m),
        .rst         (rst),
        .enable      (enable),
        .use_int     (use_int),
        .acc_int1    (acc_int1),
        .acc_sclk    (acc_sclk),
        .acc_mosi    (acc_mosi),
        .acc_miso    (acc_miso),
        .acc_cs      (acc_cs),
        .acc_x       (acc_x),
        .acc_y       (acc_y),
        .acc_z       (acc_z),
        .sample_valid(sample_valid),
        .id_ok       (id_ok),
        .busy        (busy)
    );

    always #5 clk12m = ~clk12m;

    int cyc = 0;
    always @(posedge clk12m) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Slave register model: WHO_AM_I, six sample bytes at 0x28..0x2D, writable space elsewhere.
    logic [7:0] who_am_i = 8'h33;
    logic [7:0] smp   [0:5];
    logic [7:0] wregs [0:63];

    int fr_start[$];
    int fr_len[$];
    int fr_bits[$];
    int fr_b0[$];
    int fr_b1[$];
    int n_frames  = 0;
    int n_started = 0;
    int gap_viol  = 0;

    logic       prev_cs   = 1'b1;
    logic       prev_sclk = 1'b1;
    int         bitn      = 0;
    int         cs_cnt    = 0;
    int         cs_high   = 1000;
    int         cur_start = 0;
    logic [7:0] sh        = 8'h00;
    logic [7:0] cmd       = 8'h00;
    logic [7:0] b1        = 8'h00;

    function automatic logic miso_bit(input int n);
        logic [5:0] a;
        logic [7:0] v;
        int         k;
        k = n / 8;
        if (k == 0 || !cmd[7]) return 1'b0;
        a = cmd[5:0] + (cmd[6] ? 6'(k - 1) : 6'd0);
        if (a == 6'h0F) v = who_am_i;
        else if (a >= 6'h28 && a <= 6'h2D) v = smp[int'(a) - 'h28];
        else v = wregs[a];
        return v[7 - (n % 8)];
    endfunction

    always @(negedge clk12m) begin
        if (!acc_cs) begin
            if (prev_cs) begin
                if (cs_high < 2 * CLK_DIV) gap_viol++;
                bitn      = 0;
                cs_cnt    = 0;
                cur_start = cyc;
                cmd       = 8'h00;
                b1        = 8'h00;
                n_started++;
            end
            cs_cnt++;
            if (prev_sclk && !acc_sclk) acc_miso = miso_bit(bitn);
            if (!prev_sclk && acc_sclk) begin
                sh = {sh[6:0], acc_mosi};
                bitn++;
                if (bitn % 8 == 0) begin
                    if (bitn == 8) begin
                        cmd = sh;
                    end else begin
                        if (bitn == 16) b1 = sh;
                        if (!cmd[7]) wregs[cmd[5:0] + (cmd[6] ? 6'(bitn / 8 - 2) : 6'd0)] = sh;
                    end
                end
            end
        end else begin
            if (!prev_cs) begin
                fr_start.push_back(cur_start);
                fr_len.push_back(cs_cnt);
                fr_bits.push_back(bitn);
                fr_b0.push_back(int'(cmd));
                fr_b1.push_back(int'(b1));
                n_frames++;
                cs_high = 0;
            end
            cs_high++;
        end
        prev_cs   = acc_cs;
        prev_sclk = acc_sclk;
    end

    int          sv_cnt  = 0;
    logic [47:0] sv_last = '0;
    always @(negedge clk12m) begin
        if (sample_valid) begin
            sv_cnt++;
            sv_last = {acc_x, acc_y, acc_z};
        end
    end

    function automatic int fr_get(input int which, input int i);
        if (i < 0 || i >= fr_start.size()) return -1;
        case (which)
            0:       return fr_start[i];
            1:       return fr_len[i];
            2:       return fr_bits[i];
            3:       return fr_b0[i];
            default: return fr_b1[i];
        endcase
    endfunction

    function automatic logic [47:0] exp_sample();
        return {smp[1], smp[0], smp[3], smp[2], smp[5], smp[4]};
    endfunction

    task automatic new_sample();
        for (int i = 0; i < 6; i++) smp[i] = 8'($urandom);
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int t = 0;
        while (n_frames < n && t < budget) begin @(negedge clk12m); t++; end
        chk(tag, n_frames, n);
    endtask

    task automatic wait_started(input int n, input int budget, input string tag);
        int t = 0;
        while (n_started < n && t < budget) begin @(negedge clk12m); t++; end
        chk(tag, n_started, n);
    endtask

    task automatic wait_sv(input int n, input int budget, input string tag);
        int t = 0;
        while (sv_cnt < n && t < budget) begin @(negedge clk12m); t++; end
        chk(tag, sv_cnt, n);
    endtask

    task automatic pulse_int(output int at);
        @(posedge clk12m); #1;
        acc_int1 = 1'b1;
        at = cyc;
        repeat (4) @(posedge clk12m);
        #1 acc_int1 = 1'b0;
        repeat (6) @(posedge clk12m);
    endtask

    task automatic check_init(input int f, input string tag);
        chk({tag, "_id_cmd"},   fr_get(3, f),     'h8F);
        chk({tag, "_id_len"},   fr_get(1, f),     LEN_2B);
        chk({tag, "_id_bits"},  fr_get(2, f),     16);
        chk({tag, "_c1_cmd"},   fr_get(3, f + 1), 'h20);
        chk({tag, "_c1_data"},  fr_get(4, f + 1), 'h77);
        chk({tag, "_c1_len"},   fr_get(1, f + 1), LEN_2B);
        chk({tag, "_c4_cmd"},   fr_get(3, f + 2), 'h23);
        chk({tag, "_c4_data"},  fr_get(4, f + 2), 'h88);
        chk({tag, "_c4_len"},   fr_get(1, f + 2), LEN_2B);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          f;
        int          p0;
        int          s0;
        int          sv0;
        int          lat;
        logic [47:0] exp_s;

        for (int i = 0; i < 64; i++) wregs[i] = 8'h00;
        for (int i = 0; i < 6; i++) smp[i] = 8'h00;
        rst      = 1'b1;
        enable   = 1'b0;
        use_int  = 1'b1;
        acc_int1 = 1'b0;

        repeat (3) @(posedge clk12m);
        @(negedge clk12m);
        chk("rst_cs",   acc_cs,   1);
        chk("rst_sclk", acc_sclk, 1);
        chk("rst_mosi", acc_mosi, 0);
        chk("rst_xyz",  {acc_x, acc_y, acc_z}, 0);
        chk("rst_sv",   sample_valid, 0);
        chk("rst_id",   id_ok, 0);
        chk("rst_busy", busy, 0);

        // Init sequence, interrupt mode with no pulses.
        @(posedge clk12m); #1;
        rst    = 1'b0;
        enable = 1'b1;
        wait_frames(1, 400, "init_first_frame");
        repeat (2) @(negedge clk12m);
        chk("id_ok_after_id", id_ok, 1);
        wait_frames(3, 600, "init_frames");
        check_init(0, "init");
        chk("ctrl1_written", wregs[6'h20], 8'h77);
        chk("ctrl4_written", wregs[6'h23], 8'h88);
        repeat (20) @(negedge clk12m);
        chk("busy_in_wait", busy, 0);
        repeat (1500) @(negedge clk12m);
        chk("no_read_without_int", n_frames, 3);
        chk("no_sv_without_int", sv_cnt, 0);

        // Single interrupt pulse.
        new_sample();
        exp_s = exp_sample();
        f = n_frames;
        pulse_int(p0);
        wait_sv(1, 800, "int_read_sv");
        chk("int_read_cmd",  fr_get(3, f), 'hE8);
        chk("int_read_len",  fr_get(1, f), LEN_7B);
        chk("int_read_bits", fr_get(2, f), 56);
        lat = fr_get(0, f) - p0;
        chk("int_read_latency_window", (lat >= 2 * CLK_DIV) && (lat <= 2 + 4 + 2 * CLK_DIV), 1);
        chk("int_read_sample", sv_last, exp_s);

        // Three pulses during a READ collapse into one follow-up READ.
        new_sample();
        exp_s = exp_sample();
        f  = n_frames;
        s0 = n_started;
        pulse_int(p0);
        wait_started(s0 + 1, 100, "collapse_read_start");
        repeat (30) @(posedge clk12m);
        for (int i = 0; i < 3; i++) pulse_int(p0);
        wait_sv(3, 1500, "collapse_sv");
        chk("collapse_sample", sv_last, exp_s);
        repeat (2000) @(negedge clk12m);
        chk("collapse_frames", n_frames, f + 2);
        chk("collapse_sv_total", sv_cnt, 3);
        chk("collapse_second_cmd", fr_get(3, f + 1), 'hE8);

        // Poll mode: three reads with fresh random bytes, exact period spacing.
        @(posedge clk12m); #1;
        use_int = 1'b0;
        f   = n_frames;
        sv0 = sv_cnt;
        for (int i = 0; i < 3; i++) begin
            new_sample();
            exp_s = exp_sample();
            wait_sv(sv0 + i + 1, 1500, "poll_sv");
            chk("poll_sample", sv_last, exp_s);
        end
        chk("poll_cmd", fr_get(3, f), 'hE8);
        chk("poll_len", fr_get(1, f), LEN_7B);
        chk("poll_period_1", fr_get(0, f + 1) - fr_get(0, f), POLL);
        chk("poll_period_2", fr_get(0, f + 2) - fr_get(0, f + 1), POLL);

        // enable dropped mid-READ: frame and publish complete, then IDLE.
        new_sample();
        exp_s = exp_sample();
        sv0 = sv_cnt;
        f   = n_frames;
        wait_started(n_started + 1, 1500, "drop_read_start");
        begin
            int t = 0;
            while (bitn < 20 && t < 400) begin @(negedge clk12m); t++; end
        end
        @(posedge clk12m); #1;
        enable = 1'b0;
        wait_sv(sv0 + 1, 600, "drop_sv");
        chk("drop_sample", sv_last, exp_s);
        chk("drop_len", fr_get(1, f), LEN_7B);
        repeat (5) @(negedge clk12m);
        chk("drop_busy", busy, 0);
        repeat (1500) @(negedge clk12m);
        chk("drop_no_frames", n_frames, f + 1);
        chk("drop_cs_high", acc_cs, 1);
        chk("drop_single_sv", sv_cnt, sv0 + 1);
        chk("drop_id_ok_held", id_ok, 1);

        // Re-enable with a WHO_AM_I mismatch: init still runs, reads continue.
        who_am_i = 8'h00;
        f = n_frames;
        @(posedge clk12m); #1;
        enable = 1'b1;
        wait_frames(f + 3, 1200, "reinit_frames");
        new_sample();
        exp_s = exp_sample();
        check_init(f, "reinit");
        chk("mismatch_id_ok", id_ok, 0);
        sv0 = sv_cnt;
        wait_sv(sv0 + 1, 1500, "mismatch_sv");
        chk("mismatch_sample", sv_last, exp_s);

        // rst mid-READ.
        wait_started(n_started + 1, 1500, "rst_read_start");
        repeat (100) @(posedge clk12m);
        #1 rst = 1'b1;
        sv0 = sv_cnt;
        @(posedge clk12m);
        @(negedge clk12m);
        chk("midrst_cs",   acc_cs,   1);
        chk("midrst_sclk", acc_sclk, 1);
        chk("midrst_xyz",  {acc_x, acc_y, acc_z}, 0);
        chk("midrst_sv",   sample_valid, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk12m); #1;
        rst      = 1'b0;
        who_am_i = 8'h33;
        f = n_frames;
        wait_frames(f + 3, 1200, "postrst_frames");
        check_init(f, "postrst");
        chk("postrst_id_ok", id_ok, 1);
        chk("postrst_no_sv", sv_cnt, sv0);

        chk("cs_gap_violations", gap_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
